// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate-extension path.
package imm_ext_pkg;

  localparam int EXT_MODE_W = 2;

  localparam logic [EXT_MODE_W-1:0] EXT_SIGN   = 2'b00;
  localparam logic [EXT_MODE_W-1:0] EXT_ZERO   = 2'b01;
  localparam logic [EXT_MODE_W-1:0] EXT_UPPER  = 2'b10;
  localparam logic [EXT_MODE_W-1:0] EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: sign, zero, upper-load and branch-offset forms.
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]      imm_i,
  input  logic [EXT_MODE_W-1:0] mode_i,
  output logic [DATA_W-1:0]     data_o
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;

  assign sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm_i};

  always_comb begin
    data_o = sext;
    case (mode_i)
      EXT_SIGN:   data_o = sext;
      EXT_ZERO:   data_o = zext;
      EXT_UPPER:  data_o = {imm_i, {(DATA_W-IMM_W){1'b0}}};
      // Word offset: top two sign bits fall off the end.
      EXT_BRANCH: data_o = {sext[DATA_W-3:0], 2'b00};
      default:    data_o = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake and one-entry skid buffer.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      immediate,
  input  logic [EXT_MODE_W-1:0] ext_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     world,
  output logic [TAG_W-1:0]      out_tag
);

  logic [DATA_W-1:0] ext_data;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;

  logic in_xfer;
  logic out_xfer;

  imm_extend_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm_i  (immediate),
    .mode_i (ext_mode),
    .data_o (ext_data)
  );

  // Ready depends only on the skid register, so no combinational path from out_ready.
  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer && skid_valid_q) begin
      main_data_d  = skid_data_q;
      main_tag_d   = skid_tag_q;
      skid_valid_d = 1'b0;
      if (in_xfer) begin
        skid_valid_d = 1'b1;
        skid_data_d  = ext_data;
        skid_tag_d   = in_tag;
      end
    end else if (out_xfer || !main_valid_q) begin
      main_valid_d = in_xfer;
      if (in_xfer) begin
        main_data_d = ext_data;
        main_tag_d  = in_tag;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid = main_valid_q;
  assign world     = main_data_q;
  assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: modes, backpressure, flush, reset, narrow-immediate instance.
module tb_imm_extend_stage;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] immediate;
  logic [1:0]  ext_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] world;
  logic [4:0]  out_tag;

  logic        p_flush;
  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_immediate;
  logic [1:0]  p_ext_mode;
  logic [4:0]  p_in_tag;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [31:0] p_world;
  logic [4:0]  p_out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_extend_stage #(.IMM_W(16), .DATA_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immediate (immediate),
    .ext_mode  (ext_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .world     (world),
    .out_tag   (out_tag)
  );

  imm_extend_stage #(.IMM_W(12), .DATA_W(32), .TAG_W(5)) dut_p12 (
    .clk       (clk),
    .reset     (reset),
    .flush     (p_flush),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .immediate (p_immediate),
    .ext_mode  (p_ext_mode),
    .in_tag    (p_in_tag),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .world     (p_world),
    .out_tag   (p_out_tag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag);
    in_valid  = v;
    immediate = imm;
    ext_mode  = mode;
    in_tag    = tag;
  endtask

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep[5];

  initial begin
    sweep[0] = '{16'h8001, EXT_SIGN,   32'hFFFF8001};
    sweep[1] = '{16'h8001, EXT_ZERO,   32'h00008001};
    sweep[2] = '{16'h1234, EXT_UPPER,  32'h12340000};
    sweep[3] = '{16'hFFFF, EXT_BRANCH, 32'hFFFFFFFC};
    sweep[4] = '{16'h0004, EXT_BRANCH, 32'h00000010};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, EXT_SIGN, '0);
    p_flush = 1'b0; p_in_valid = 1'b0; p_immediate = '0;
    p_ext_mode = EXT_SIGN; p_in_tag = '0; p_out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset world", world, 32'd0);
    check("reset out_tag", {27'b0, out_tag}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);

    // Mode sweep, streaming one item per cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sweep[i].imm, sweep[i].mode, 5'(i + 10));
      step();
      check($sformatf("sweep%0d valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("sweep%0d world", i), world, sweep[i].exp);
      check($sformatf("sweep%0d tag", i), {27'b0, out_tag}, 32'(i + 10));
    end
    drive(1'b0, '0, EXT_SIGN, '0);
    step();
    check("sweep drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 16'd1, EXT_ZERO, 5'd1);
    step();
    check("bp t1 main tag", {27'b0, out_tag}, 32'd1);
    check("bp t1 in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 16'd2, EXT_ZERO, 5'd2);
    step();
    check("bp t2 in_ready low", {31'b0, in_ready}, 32'd0);
    check("bp t2 main holds", {27'b0, out_tag}, 32'd1);
    drive(1'b1, 16'd3, EXT_ZERO, 5'd3);
    step();
    check("bp t3 held off", {31'b0, in_ready}, 32'd0);
    check("bp stable world", world, 32'd1);
    check("bp stable tag", {27'b0, out_tag}, 32'd1);
    // Release with input still pending while skid is full
    out_ready = 1'b1;
    step();
    check("rel skid moved up", {27'b0, out_tag}, 32'd2);
    check("rel world", world, 32'd2);
    check("rel in_ready back", {31'b0, in_ready}, 32'd1);
    step();
    check("rel t3 delivered", {27'b0, out_tag}, 32'd3);
    check("rel t3 world", world, 32'd3);
    drive(1'b0, '0, EXT_SIGN, '0);
    step();
    check("rel drained", {31'b0, out_valid}, 32'd0);

    // Flush mid-stall with an input presented
    out_ready = 1'b0;
    drive(1'b1, 16'd4, EXT_ZERO, 5'd4);
    step();
    drive(1'b1, 16'd5, EXT_ZERO, 5'd5);
    step();
    check("fl both full", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 16'd6, EXT_ZERO, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, EXT_SIGN, '0);
    check("fl out_valid", {31'b0, out_valid}, 32'd0);
    check("fl in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check("fl input dropped", {31'b0, out_valid}, 32'd0);

    // Reset during a stream
    drive(1'b1, 16'd7, EXT_ZERO, 5'd7);
    step();
    check("rs pre tag", {27'b0, out_tag}, 32'd7);
    drive(1'b1, 16'd8, EXT_ZERO, 5'd8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs out_valid", {31'b0, out_valid}, 32'd0);
    check("rs world", world, 32'd0);
    check("rs out_tag", {27'b0, out_tag}, 32'd0);
    check("rs in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 16'd9, EXT_ZERO, 5'd9);
    step();
    check("rs first valid", {31'b0, out_valid}, 32'd1);
    check("rs first world", world, 32'd9);
    check("rs first tag", {27'b0, out_tag}, 32'd9);
    drive(1'b0, '0, EXT_SIGN, '0);

    // Narrow immediate instance
    p_in_valid = 1'b1; p_immediate = 12'h800; p_ext_mode = EXT_SIGN; p_in_tag = 5'd1;
    step();
    check("p12 sign", p_world, 32'hFFFFF800);
    p_ext_mode = EXT_UPPER; p_in_tag = 5'd2;
    step();
    check("p12 upper", p_world, 32'h80000000);
    p_ext_mode = EXT_BRANCH; p_in_tag = 5'd3;
    step();
    check("p12 branch", p_world, 32'hFFFFE000);
    check("p12 tag", {27'b0, p_out_tag}, 32'd3);
    p_in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Registered, parametrised immediate-extension stage for the MIPS decode path, replacing the fixed 16→32 sign extender. It takes an IMM_W-bit instruction immediate and a mode code, produces the DATA_W-bit operand (sign, zero, upper-load or branch-offset form), and holds it in an output register. A valid/ready handshake with a one-entry skid buffer lets the stage absorb one cycle of downstream stall without dropping data. It sits between the instruction decoder and the ID/EX operand mux.

## Interface
- IMM_W, 16, immediate field width
- DATA_W, 32, datapath width; must satisfy DATA_W >= IMM_W + 2
- TAG_W, 5, width of the opaque sideband tag (destination register index) carried with each item
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-high reset
- flush  in  1  drop all held items (pipeline squash)
- in_valid  in  1  input item present
- in_ready  out  1  stage can accept an item this cycle
- immediate  in  IMM_W  raw immediate
- ext_mode  in  2  extension mode, see Operation
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output item present
- out_ready  in  1  downstream accepts the item this cycle
- world  out  DATA_W  extended operand
- out_tag  out  TAG_W  tag of the item on world

## Operation
- Modes (ext_mode):
  - 00 SIGN: {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}
  - 01 ZERO: {(DATA_W-IMM_W){0}, imm}
  - 10 UPPER: {imm, (DATA_W-IMM_W){0}} (LUI form)
  - 11 BRANCH: sign-extend, then shift left 2; the two low bits are 0 and the top two bits of the sign-extended value are discarded.
- Extension is computed combinationally at the input; storage holds only extended values plus tags.
- Storage: main register (out_valid, world, out_tag) and skid register (skid_valid, skid_data, skid_tag).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !skid_valid, derived from a register only; it has no combinational path from out_ready.
- Main register loads on an input transfer when it is empty or is transferring out this cycle. Otherwise the input item goes to the skid register.
- On an output transfer with skid_valid=1, the skid contents move into the main register and skid_valid clears. An input accepted in the same cycle then loads the skid register.
- Order is strictly FIFO. No item is duplicated or lost except by flush or reset.
- flush: on the next edge, out_valid and skid_valid are 0. An input presented in the flush cycle is discarded. flush overrides every transfer in that cycle.
- reset: same effect as flush, and it also clears world and out_tag to 0. Inputs are ignored while reset is high.

## Timing
- Latency: 1 cycle. An item accepted at edge N appears on world/out_valid after edge N when the main register is free.
- Throughput: 1 item/cycle while out_ready=1.
- Stall: while out_ready=0 with the main register full, exactly one further item is accepted, into the skid register. in_ready then drops in the following cycle.
- Recovery: the first out_ready=1 cycle drains the main register, the skid item moves up, and in_ready returns to 1 in the next cycle.
- Reset values: out_valid=0, world=0, out_tag=0, skid_valid=0, so in_ready=1 from the first cycle after reset.
- world and out_tag hold stable while out_valid=1 && out_ready=0.
- Reset or flush mid-stall: both entries are dropped. in_ready=1 and out_valid=0 after the edge.

## Structure
- Shared package `imm_ext_pkg` holds:
  - the mode constants EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11;
  - the 2-bit mode width constant.
- Sub-module `imm_extend_core` (combinational, parameters IMM_W/DATA_W) implements the mode mux. It is instantiated once at the input and unit-testable alone.
- Top level holds the two-entry register pair and the handshake logic. There is no other state.

## Test plan
- Mode sweep, DATA_W=32/IMM_W=16, out_ready=1:
  - 0x8001 SIGN → 0xFFFF8001
  - 0x8001 ZERO → 0x00008001
  - 0x1234 UPPER → 0x12340000
  - 0xFFFF BRANCH → 0xFFFFFFFC
  - 0x0004 BRANCH → 0x00000010
  - each result appears 1 cycle after acceptance.
- Backpressure: hold out_ready=0 and send tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready falls the cycle after tag 2.
  - Tag 3 is held off.
  - Releasing out_ready delivers 1,2,3 in order with no gaps beyond one cycle.
- Simultaneous events: main and skid registers full; out_ready=1 and in_valid=1 in the same cycle.
  - The skid item moves to main.
  - The input is not accepted (in_ready=0 that cycle) and is taken next cycle.
  - Order is preserved.
- Flush mid-stall: both entries full and in_valid=1 when flush=1.
  - Next cycle: out_valid=0, in_ready=1.
  - The flushed-cycle input never appears on world.
- Reset mid-operation: assert reset during a stream.
  - Next cycle: out_valid=0, world=0, out_tag=0, in_ready=1.
  - The first item after reset is released with 1-cycle latency.
- Parameter check: IMM_W=12, DATA_W=32 with 0x800 SIGN → 0xFFFFF800 and UPPER → 0x80000000.
